// File: rtl/spm_cisr_row_sched.sv
// Row-length scheduler for the CISR decoder: buffers incoming row lengths
// and hands them to popping channels in order, sequencing one SpMV pass.
module spm_cisr_row_sched #(
    parameter int CHAN_NUM = 16,
    parameter int LEN_W    = 32,
    parameter int DEPTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [15:0]               num_rows,
    input  logic [LEN_W-1:0]          in_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHAN_NUM-1:0]       row_len_pop,
    output logic [LEN_W*CHAN_NUM-1:0] row_len,
    output logic                      bubble,
    output logic                      spmv_init,
    output logic                      busy,
    output logic                      done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LEN_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    fifo_cnt;
    logic [15:0]      rows_q;
    logic [15:0]      acc_cnt;
    logic [15:0]      disp_cnt;
    logic [15:0]      disp_nxt;
    logic [15:0]      remain;
    logic [15:0]      need;
    logic [CW-1:0]    need_c;
    logic [CW-1:0]    pop_num;
    logic [CW-1:0]    rank;
    logic             fits;
    logic             consume;
    logic             push;

    // Count requesting channels this cycle
    always_comb begin
        pop_num = '0;
        for (int k = 0; k < CHAN_NUM; k++) begin
            pop_num = pop_num + CW'(row_len_pop[k]);
        end
    end

    // Grant size is capped by the rows still owed to the decoder
    always_comb begin
        remain   = rows_q - disp_cnt;
        need     = (16'(pop_num) < remain) ? 16'(pop_num) : remain;
        need_c   = need[CW-1:0];
        fits     = fifo_cnt >= need_c;
        consume  = (state == RUN) && fits;
        in_ready = (state == RUN) && (fifo_cnt < CW'(DEPTH))
                   && (acc_cnt < rows_q);
        push     = in_valid && in_ready;
        disp_nxt = disp_cnt + (consume ? need : 16'd0);
        busy     = state != IDLE;
    end

    // Hand consecutive FIFO entries to popping channels, lowest index first
    always_comb begin
        row_len = '0;
        rank    = '0;
        for (int k = 0; k < CHAN_NUM; k++) begin
            if (consume && row_len_pop[k]) begin
                if (rank < need_c) begin
                    row_len[k*LEN_W +: LEN_W] = mem[rd_ptr + rank[AW-1:0]];
                end
                rank = rank + CW'(1);
            end
        end
    end

    // Pass sequencing and per-state stall/strobe outputs
    always_comb begin
        state_nxt = state;
        bubble    = 1'b1;
        spmv_init = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = INIT;
            end
            INIT: begin
                spmv_init = 1'b1;
                state_nxt = (rows_q == 16'd0) ? DRAIN : RUN;
            end
            RUN: begin
                bubble = !fits;
                if (disp_nxt == rows_q) state_nxt = DRAIN;
            end
            DRAIN: begin
                bubble = 1'b0;
                if (&row_len_pop) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointers and counters; INIT wipes any leftovers of a prior pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rows_q   <= '0;
            acc_cnt  <= '0;
            disp_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) rows_q <= num_rows;
            if (state == INIT) begin
                acc_cnt  <= '0;
                disp_cnt <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    acc_cnt <= acc_cnt + 16'd1;
                end
                if (consume) begin
                    rd_ptr   <= rd_ptr + need_c[AW-1:0];
                    disp_cnt <= disp_nxt;
                end
                fifo_cnt <= fifo_cnt + CW'(push) - (consume ? need_c : '0);
            end
        end
    end

    // Row-length storage; written data is visible from the next cycle
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_len;
    end

    a_no_overread : assert property (@(posedge clk) disable iff (!rst_n)
        consume |-> (need_c <= fifo_cnt));
    a_acc_bound : assert property (@(posedge clk) disable iff (!rst_n)
        (state == RUN || state == DRAIN) |-> (acc_cnt <= rows_q));
    a_disp_bound : assert property (@(posedge clk) disable iff (!rst_n)
        (state == RUN || state == DRAIN) |-> (disp_cnt <= acc_cnt));

endmodule
